// File: rtl/lsu_pkg.sv
// Shared types, mode encodings and the alignment rule for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    READ_ADDR = 3'd2,
    READ_DATA = 3'd3,
    RESP      = 3'd4
  } lsu_state_t;

  localparam logic [1:0] MODE_WORD = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b10;
  localparam logic [1:0] MODE_BYTE = 2'b11;

  // Halves need an even address; words (including the 01 alias) need a
  // multiple of four; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] mode, input logic [1:0] addr_lo);
    logic mis_v;
    case (mode)
      MODE_HALF: mis_v = addr_lo[0];
      MODE_BYTE: mis_v = 1'b0;
      default:   mis_v = (addr_lo != 2'b00);
    endcase
    return mis_v;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Little-endian lane selection and sign/zero extension of a 32-bit read word.
module load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [1:0]  addr_in,
  input  logic [1:0]  mode_in,
  input  logic        unsigned_in,
  output logic [31:0] result_out
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed lane and widen it according to the access mode.
  always_comb begin
    byte_s     = 8'h00;
    half_s     = 16'h0000;
    result_out = word_in;
    case (addr_in)
      2'b00:   byte_s = word_in[7:0];
      2'b01:   byte_s = word_in[15:8];
      2'b10:   byte_s = word_in[23:16];
      2'b11:   byte_s = word_in[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = addr_in[1] ? word_in[31:16] : word_in[15:0];
    case (mode_in)
      MODE_BYTE: result_out = unsigned_in ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
      MODE_HALF: result_out = unsigned_in ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
      default:   result_out = word_in;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage access controller: one load/store per handshake, registered
// memory-side controls, one-cycle synchronous read sequencing, lane
// extraction, misalignment rejection and pipeline stall generation.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic                     req_valid_in,
  output logic                     req_ready_out,
  input  logic                     req_write_in,
  input  logic [1:0]               memMode_in,
  input  logic                     unsigned_in,
  input  logic [31:0]              address_in,
  input  logic [31:0]              store_data_in,
  output logic                     resp_valid_out,
  output logic [31:0]              load_data_out,
  output logic                     misaligned_out,
  output logic                     stall_out,
  output logic                     mem_write_out,
  output logic                     mem_read_en_out,
  output logic [1:0]               mem_memMode_out,
  output logic [ADDRESS_WIDTH-1:0] mem_address_out,
  output logic [31:0]              mem_write_data_out,
  input  logic [31:0]              mem_read_data_in
);

  lsu_state_t state_r;
  lsu_state_t state_next_s;

  logic                     accept_s;
  logic                     req_mis_s;
  logic                     mem_active_next_s;
  logic [ADDRESS_WIDTH-1:0] req_addr_s;
  logic [1:0]               req_mode_s;
  logic [31:0]              req_data_s;
  logic [31:0]              extract_s;

  logic [ADDRESS_WIDTH-1:0] addr_r;
  logic [1:0]               mode_r;
  logic                     unsigned_r;
  logic [31:0]              store_data_r;

  logic                     req_ready_r;
  logic                     resp_valid_r;
  logic                     misaligned_r;
  logic [31:0]              load_data_r;
  logic                     mem_write_r;
  logic                     mem_read_en_r;
  logic [1:0]               mem_mode_r;
  logic [ADDRESS_WIDTH-1:0] mem_addr_r;
  logic [31:0]              mem_wdata_r;

  // Address bits above the memory width simply wrap and are not used.
  generate
    if (ADDRESS_WIDTH < 32) begin : g_addr_wrap
      logic unused_addr_hi_s;
      assign unused_addr_hi_s = ^address_in[31:ADDRESS_WIDTH];
    end
  endgenerate

  // Request fields come straight from the inputs on the acceptance cycle,
  // from the captured copy afterwards.
  always_comb begin
    accept_s   = 1'b0;
    req_mis_s  = 1'b0;
    req_addr_s = {ADDRESS_WIDTH{1'b0}};
    req_mode_s = 2'b00;
    req_data_s = 32'h0000_0000;
    accept_s   = (state_r == IDLE) && req_valid_in;
    req_mis_s  = is_misaligned(memMode_in, address_in[1:0]);
    if (accept_s) begin
      req_addr_s = address_in[ADDRESS_WIDTH-1:0];
      req_mode_s = memMode_in;
      req_data_s = store_data_in;
    end else begin
      req_addr_s = addr_r;
      req_mode_s = mode_r;
      req_data_s = store_data_r;
    end
  end

  // Next-state selection; misaligned requests skip memory and go straight to RESP.
  always_comb begin
    state_next_s      = state_r;
    mem_active_next_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid_in) begin
          if (req_mis_s) begin
            state_next_s = RESP;
          end else if (req_write_in) begin
            state_next_s = WRITE;
          end else begin
            state_next_s = READ_ADDR;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WRITE:     state_next_s = RESP;
      READ_ADDR: state_next_s = READ_DATA;
      READ_DATA: state_next_s = RESP;
      RESP:      state_next_s = IDLE;
      default:   state_next_s = IDLE;
    endcase
    mem_active_next_s = (state_next_s == WRITE) || (state_next_s == READ_ADDR) ||
                        (state_next_s == READ_DATA);
  end

  // Stall while memory work is pending or a request is waiting in IDLE; released in RESP.
  always_comb begin
    stall_out = 1'b0;
    stall_out = (state_r == WRITE) || (state_r == READ_ADDR) || (state_r == READ_DATA) ||
                ((state_r == IDLE) && req_valid_in);
  end

  // State register.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Capture the request on acceptance and hold it for the rest of the access.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      addr_r       <= {ADDRESS_WIDTH{1'b0}};
      mode_r       <= 2'b00;
      unsigned_r   <= 1'b0;
      store_data_r <= 32'h0000_0000;
    end else if (accept_s) begin
      addr_r       <= address_in[ADDRESS_WIDTH-1:0];
      mode_r       <= memMode_in;
      unsigned_r   <= unsigned_in;
      store_data_r <= store_data_in;
    end
  end

  // Memory-side controls, registered from the next state and zero whenever memory is idle.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      mem_write_r   <= 1'b0;
      mem_read_en_r <= 1'b0;
      mem_mode_r    <= 2'b00;
      mem_addr_r    <= {ADDRESS_WIDTH{1'b0}};
      mem_wdata_r   <= 32'h0000_0000;
    end else begin
      mem_write_r   <= (state_next_s == WRITE);
      mem_read_en_r <= (state_next_s == READ_ADDR) || (state_next_s == READ_DATA);
      mem_mode_r    <= mem_active_next_s ? req_mode_s : 2'b00;
      mem_addr_r    <= mem_active_next_s ? req_addr_s : {ADDRESS_WIDTH{1'b0}};
      mem_wdata_r   <= (state_next_s == WRITE) ? req_data_s : 32'h0000_0000;
    end
  end

  // Handshake and response flags, registered so they line up with the state they describe.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      misaligned_r <= 1'b0;
    end else begin
      req_ready_r  <= (state_next_s == IDLE);
      resp_valid_r <= (state_next_s == RESP);
      misaligned_r <= accept_s && req_mis_s;
    end
  end

  // Load result: extracted at the end of READ_DATA, cleared for store and
  // misaligned responses, otherwise held.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      load_data_r <= 32'h0000_0000;
    end else if (state_r == READ_DATA) begin
      load_data_r <= extract_s;
    end else if (state_next_s == RESP) begin
      load_data_r <= 32'h0000_0000;
    end
  end

  load_extract u_load_extract (
    .word_in     (mem_read_data_in),
    .addr_in     (addr_r[1:0]),
    .mode_in     (mode_r),
    .unsigned_in (unsigned_r),
    .result_out  (extract_s)
  );

  assign req_ready_out      = req_ready_r;
  assign resp_valid_out     = resp_valid_r;
  assign misaligned_out     = misaligned_r;
  assign load_data_out      = load_data_r;
  assign mem_write_out      = mem_write_r;
  assign mem_read_en_out    = mem_read_en_r;
  assign mem_memMode_out    = mem_mode_r;
  assign mem_address_out    = mem_addr_r;
  assign mem_write_data_out = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-array data memory and
// a byte-level reference model of loads, stores and alignment.
module tb_load_store_unit;

  logic        clock_in;
  logic        reset_in;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_write_in;
  logic [1:0]  memMode_in;
  logic        unsigned_in;
  logic [31:0] address_in;
  logic [31:0] store_data_in;
  logic        resp_valid_out;
  logic [31:0] load_data_out;
  logic        misaligned_out;
  logic        stall_out;
  logic        mem_write_out;
  logic        mem_read_en_out;
  logic [1:0]  mem_memMode_out;
  logic [7:0]  mem_address_out;
  logic [31:0] mem_write_data_out;
  logic [31:0] mem_read_data_in;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] dev_mem [256];
  logic [7:0] exp_mem [256];
  logic       sync_mem;

  load_store_unit #(.ADDRESS_WIDTH(8)) dut (
    .clock_in           (clock_in),
    .reset_in           (reset_in),
    .req_valid_in       (req_valid_in),
    .req_ready_out      (req_ready_out),
    .req_write_in       (req_write_in),
    .memMode_in         (memMode_in),
    .unsigned_in        (unsigned_in),
    .address_in         (address_in),
    .store_data_in      (store_data_in),
    .resp_valid_out     (resp_valid_out),
    .load_data_out      (load_data_out),
    .misaligned_out     (misaligned_out),
    .stall_out          (stall_out),
    .mem_write_out      (mem_write_out),
    .mem_read_en_out    (mem_read_en_out),
    .mem_memMode_out    (mem_memMode_out),
    .mem_address_out    (mem_address_out),
    .mem_write_data_out (mem_write_data_out),
    .mem_read_data_in   (mem_read_data_in)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // Data memory: lane-steering write port, registered word read port.
  always @(posedge clock_in) begin : mem_device
    if (sync_mem) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= exp_mem[i];
    end else if (mem_write_out) begin
      case (mem_memMode_out)
        2'b11: dev_mem[mem_address_out] <= mem_write_data_out[7:0];
        2'b10: begin
          dev_mem[mem_address_out]        <= mem_write_data_out[7:0];
          dev_mem[mem_address_out + 8'd1] <= mem_write_data_out[15:8];
        end
        default: begin
          for (int i = 0; i < 4; i++)
            dev_mem[{mem_address_out[7:2], 2'b00} + 8'(i)] <= mem_write_data_out[8*i +: 8];
        end
      endcase
    end
    if (mem_read_en_out)
      mem_read_data_in <= {dev_mem[{mem_address_out[7:2], 2'b11}], dev_mem[{mem_address_out[7:2], 2'b10}],
                           dev_mem[{mem_address_out[7:2], 2'b01}], dev_mem[{mem_address_out[7:2], 2'b00}]};
  end

  // Reference rules, expressed on bytes.
  function automatic logic model_mis(input logic [1:0] mode, input logic [7:0] a);
    if (mode == 2'b11) return 1'b0;
    if (mode == 2'b10) return a[0];
    return (a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] model_load(input logic [7:0] a, input logic [1:0] mode, input logic uns);
    logic [7:0] a1, a2, a3;
    logic [7:0] b;
    logic [15:0] h;
    a1 = a + 8'd1; a2 = a + 8'd2; a3 = a + 8'd3;
    if (mode == 2'b11) begin
      b = exp_mem[a];
      return uns ? {24'h0, b} : {{24{b[7]}}, b};
    end
    if (mode == 2'b10) begin
      h = {exp_mem[a1], exp_mem[a]};
      return uns ? {16'h0, h} : {{16{h[15]}}, h};
    end
    return {exp_mem[a3], exp_mem[a2], exp_mem[a1], exp_mem[a]};
  endfunction

  task automatic model_store(input logic [7:0] a, input logic [1:0] mode, input logic [31:0] d);
    if (mode == 2'b11) begin
      exp_mem[a] = d[7:0];
    end else if (mode == 2'b10) begin
      exp_mem[a] = d[7:0]; exp_mem[a + 8'd1] = d[15:8];
    end else begin
      for (int i = 0; i < 4; i++) exp_mem[a + 8'(i)] = d[8*i +: 8];
    end
  endtask

  // Drives one request, then observes until the response (bounded).
  task automatic issue_req(input logic wr, input logic [1:0] mode, input logic uns,
                           input logic [31:0] addr, input logic [31:0] data,
                           output int lat, output logic [31:0] ld, output logic mis,
                           output logic [15:0] stall_hist, output int wr_cnt, output int rd_cnt,
                           output logic resp_after);
    @(negedge clock_in);
    req_valid_in = 1'b1; req_write_in = wr; memMode_in = mode;
    unsigned_in = uns; address_in = addr; store_data_in = data;
    #1;
    stall_hist = 16'h0; stall_hist[0] = stall_out;
    wr_cnt = 0; rd_cnt = 0; lat = 0; ld = 32'h0; mis = 1'b0; resp_after = 1'b0;
    @(posedge clock_in); #1;
    req_valid_in = 1'b0;
    while (lat < 10) begin
      @(negedge clock_in);
      lat++;
      stall_hist[lat] = stall_out;
      if (mem_write_out) wr_cnt++;
      if (mem_read_en_out) rd_cnt++;
      if (resp_valid_out) begin
        ld = load_data_out; mis = misaligned_out;
        break;
      end
    end
    @(negedge clock_in);
    resp_after = resp_valid_out;
  endtask

  task automatic test_reset();
    @(negedge clock_in);
    total_cnt++;
    if (req_ready_out !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready_out); else pass_cnt++;
    total_cnt++;
    if ({resp_valid_out, misaligned_out, stall_out, mem_write_out, mem_read_en_out} !== 5'b00000)
      $display("FAIL reset_flags got %b want 00000", {resp_valid_out, misaligned_out, stall_out, mem_write_out, mem_read_en_out});
    else pass_cnt++;
    total_cnt++;
    if ({load_data_out, mem_memMode_out, mem_address_out, mem_write_data_out} !== 74'h0)
      $display("FAIL reset_data got %h/%h/%h/%h want zeros", load_data_out, mem_memMode_out, mem_address_out, mem_write_data_out);
    else pass_cnt++;
  endtask

  task automatic test_directed_loads();
    logic [1:0]  modes [5] = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b00};
    logic        unss  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] addrs [5] = '{32'h10, 32'h13, 32'h12, 32'h10, 32'h10};
    logic [31:0] exps  [5] = '{32'hFFFFFFA5, 32'h00000080, 32'hFFFF8012, 32'h0000F0A5, 32'h8012F0A5};
    int lat, wc, rc; logic [31:0] ld; logic mis, ra; logic [15:0] sh;
    for (int i = 0; i < 5; i++) begin
      issue_req(1'b0, modes[i], unss[i], addrs[i], 32'h0, lat, ld, mis, sh, wc, rc, ra);
      total_cnt++;
      if (lat !== 3) $display("FAIL load%0d_latency got %0d want 3", i, lat); else pass_cnt++;
      total_cnt++;
      if (ld !== exps[i]) $display("FAIL load%0d_data got %h want %h", i, ld, exps[i]); else pass_cnt++;
      total_cnt++;
      if ({mis, ra, sh[3:0]} !== 6'b000111) $display("FAIL load%0d_flags mis/resp_after/stall got %b want 000111", i, {mis, ra, sh[3:0]}); else pass_cnt++;
      total_cnt++;
      if (wc !== 0 || rc !== 2) $display("FAIL load%0d_enables got wr=%0d rd=%0d want 0/2", i, wc, rc); else pass_cnt++;
    end
    repeat (2) @(negedge clock_in);
    total_cnt++;
    if (load_data_out !== 32'h8012F0A5) $display("FAIL load_hold got %h want 8012f0a5", load_data_out); else pass_cnt++;
  endtask

  task automatic test_store();
    int lat, wc, rc; logic [31:0] ld; logic mis, ra; logic [15:0] sh;
    issue_req(1'b1, 2'b11, 1'b0, 32'h11, 32'h00000077, lat, ld, mis, sh, wc, rc, ra);
    model_store(8'h11, 2'b11, 32'h00000077);
    total_cnt++;
    if (lat !== 2) $display("FAIL sb_latency got %0d want 2", lat); else pass_cnt++;
    total_cnt++;
    if (wc !== 1 || rc !== 0) $display("FAIL sb_enables got wr=%0d rd=%0d want 1/0", wc, rc); else pass_cnt++;
    total_cnt++;
    if ({ld, mis, sh[2:0]} !== {32'h0, 1'b0, 3'b011}) $display("FAIL sb_resp got data=%h mis=%b stall=%b want 0/0/011", ld, mis, sh[2:0]); else pass_cnt++;
    issue_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, lat, ld, mis, sh, wc, rc, ra);
    total_cnt++;
    if (ld !== 32'h801277A5) $display("FAIL sb_readback got %h want 801277a5", ld); else pass_cnt++;
  endtask

  task automatic test_misaligned();
    logic        wrs   [2] = '{1'b0, 1'b1};
    logic [1:0]  modes [2] = '{2'b00, 2'b10};
    logic [31:0] addrs [2] = '{32'h12, 32'h11};
    int lat, wc, rc; logic [31:0] ld; logic mis, ra; logic [15:0] sh;
    for (int i = 0; i < 2; i++) begin
      issue_req(wrs[i], modes[i], 1'b0, addrs[i], 32'hDEADBEEF, lat, ld, mis, sh, wc, rc, ra);
      total_cnt++;
      if (lat !== 1 || mis !== 1'b1) $display("FAIL misaligned%0d_resp got lat=%0d mis=%b want 1/1", i, lat, mis); else pass_cnt++;
      total_cnt++;
      if (wc !== 0 || rc !== 0 || ld !== 32'h0) $display("FAIL misaligned%0d_quiet got wr=%0d rd=%0d data=%h want 0/0/0", i, wc, rc, ld); else pass_cnt++;
      total_cnt++;
      if (sh[1:0] !== 2'b01 || ra !== 1'b0) $display("FAIL misaligned%0d_stall got %b/%b want 01/0", i, sh[1:0], ra); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int acc [2];
    int nacc = 0;
    int resp_q [$];
    int r0, r1;
    logic switched = 1'b0;
    logic [31:0] first_ld = 32'h0;
    logic [31:0] exp_ld;
    logic [31:0] sw_data;
    exp_ld = model_load(8'h10, 2'b00, 1'b0);
    sw_data = $urandom;
    acc[0] = -100; acc[1] = -100;
    @(negedge clock_in);
    req_valid_in = 1'b1; req_write_in = 1'b0; memMode_in = 2'b00; unsigned_in = 1'b0;
    address_in = 32'h10; store_data_in = 32'h0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (req_ready_out && req_valid_in) begin
        if (nacc < 2) acc[nacc] = cyc;
        nacc++;
      end
      if (resp_valid_out) begin
        resp_q.push_back(cyc);
        if (resp_q.size() == 1) first_ld = load_data_out;
      end
      if (resp_q.size() == 2) break;
      @(posedge clock_in); #1;
      if (nacc == 1 && !switched) begin
        req_write_in = 1'b1; address_in = 32'h20; store_data_in = sw_data; switched = 1'b1;
      end else if (nacc >= 2) begin
        req_valid_in = 1'b0;
      end
      @(negedge clock_in);
    end
    req_valid_in = 1'b0;
    model_store(8'h20, 2'b00, sw_data);
    @(negedge clock_in);
    total_cnt++;
    if (resp_valid_out !== 1'b0) $display("FAIL b2b_resp_width got %b want 0", resp_valid_out); else pass_cnt++;
    r0 = (resp_q.size() > 0) ? resp_q[0] : -1;
    r1 = (resp_q.size() > 1) ? resp_q[1] : -1;
    total_cnt++;
    if (nacc !== 2 || acc[1] - acc[0] !== 4) $display("FAIL b2b_accept got n=%0d gap=%0d want 2/4", nacc, acc[1] - acc[0]); else pass_cnt++;
    total_cnt++;
    if (resp_q.size() !== 2 || r0 !== acc[0] + 3 || r1 !== acc[1] + 2)
      $display("FAIL b2b_resp_cycles got %0d,%0d want %0d,%0d", r0, r1, acc[0] + 3, acc[1] + 2);
    else pass_cnt++;
    total_cnt++;
    if (first_ld !== exp_ld) $display("FAIL b2b_load got %h want %h", first_ld, exp_ld); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic seen;
    int lat, wc, rc; logic [31:0] ld; logic mis, ra; logic [15:0] sh;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock_in);
      req_valid_in = 1'b1; req_write_in = (k == 1); memMode_in = 2'b00; unsigned_in = 1'b0;
      address_in = (k == 1) ? 32'h18 : 32'h14; store_data_in = $urandom;
      @(posedge clock_in); #1;
      req_valid_in = 1'b0;
      @(negedge clock_in);
      if (k == 0) @(negedge clock_in);
      total_cnt++;
      if ((k == 0 ? mem_read_en_out : mem_write_out) !== 1'b1) $display("FAIL rst%0d_pre_enable got 0 want 1", k); else pass_cnt++;
      reset_in = 1'b1;
      #1;
      total_cnt++;
      if ({req_ready_out, resp_valid_out, misaligned_out, stall_out, mem_write_out, mem_read_en_out} !== 6'b100000)
        $display("FAIL rst%0d_flags got %b want 100000", k, {req_ready_out, resp_valid_out, misaligned_out, stall_out, mem_write_out, mem_read_en_out});
      else pass_cnt++;
      total_cnt++;
      if ({load_data_out, mem_memMode_out, mem_address_out, mem_write_data_out} !== 74'h0)
        $display("FAIL rst%0d_data got %h/%h/%h want zeros", k, load_data_out, mem_address_out, mem_write_data_out);
      else pass_cnt++;
      @(negedge clock_in);
      reset_in = 1'b0;
      seen = 1'b0;
      repeat (4) begin
        @(negedge clock_in);
        if (resp_valid_out) seen = 1'b1;
      end
      total_cnt++;
      if (seen !== 1'b0) $display("FAIL rst%0d_no_resp got resp want none", k); else pass_cnt++;
    end
    issue_req(1'b0, 2'b00, 1'b0, 32'h18, 32'h0, lat, ld, mis, sh, wc, rc, ra);
    total_cnt++;
    if (lat !== 3 || ld !== model_load(8'h18, 2'b00, 1'b0))
      $display("FAIL rst_recover got lat=%0d data=%h want 3/%h", lat, ld, model_load(8'h18, 2'b00, 1'b0));
    else pass_cnt++;
  endtask

  task automatic test_random();
    int lat, wc, rc; logic [31:0] ld; logic mis, ra; logic [15:0] sh;
    logic wr, uns, emis; logic [1:0] mode; logic [31:0] addr, data, eld; int elat;
    for (int n = 0; n < 80; n++) begin
      wr = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
      mode = 2'($urandom_range(0, 3)); addr = $urandom; data = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (mode == 2'b10) addr[0] = 1'b0;
        if (mode[1] == 1'b0) addr[1:0] = 2'b00;
      end
      emis = model_mis(mode, addr[7:0]);
      elat = emis ? 1 : (wr ? 2 : 3);
      eld  = (emis || wr) ? 32'h0 : model_load(addr[7:0], mode, uns);
      issue_req(wr, mode, uns, addr, data, lat, ld, mis, sh, wc, rc, ra);
      if (!emis && wr) model_store(addr[7:0], mode, data);
      total_cnt++;
      if (lat !== elat || mis !== emis) $display("FAIL rand%0d_timing got lat=%0d mis=%b want %0d/%b", n, lat, mis, elat, emis); else pass_cnt++;
      total_cnt++;
      if (ld !== eld) $display("FAIL rand%0d_data got %h want %h (mode %b addr %h)", n, ld, eld, mode, addr); else pass_cnt++;
      total_cnt++;
      if (wc !== ((!emis && wr) ? 1 : 0) || rc !== ((!emis && !wr) ? 2 : 0))
        $display("FAIL rand%0d_enables got wr=%0d rd=%0d", n, wc, rc);
      else pass_cnt++;
    end
  endtask

  task automatic test_memory();
    int bad = 0;
    @(negedge clock_in);
    for (int i = 0; i < 256; i++) if (dev_mem[i] !== exp_mem[i]) bad++;
    total_cnt++;
    if (bad !== 0) $display("FAIL memory_image got %0d differing bytes want 0", bad); else pass_cnt++;
  endtask

  initial begin
    reset_in = 1'b1; req_valid_in = 1'b0; req_write_in = 1'b0; memMode_in = 2'b00;
    unsigned_in = 1'b0; address_in = 32'h0; store_data_in = 32'h0; sync_mem = 1'b1;
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'($urandom);
    exp_mem[8'h10] = 8'hA5; exp_mem[8'h11] = 8'hF0; exp_mem[8'h12] = 8'h12; exp_mem[8'h13] = 8'h80;
    @(posedge clock_in);
    @(negedge clock_in);
    sync_mem = 1'b0;
    test_reset();
    reset_in = 1'b0;
    test_directed_loads();
    test_store();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_memory();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
